pcie_mwr_tlp_packer: RTL and testbench

- Converts one AXI write burst (AW + W) into one PCIe Memory-Write TLP stream.
- Header fields come from static config inputs; the TLP is header-on-first-beat with a payload stream behind it.
- Generalises the single-beat, 128-bit AW/W-to-header path of the PCIe block: parametrised data width, multi-beat bursts, a W-side FIFO, error responses and output backpressure.
- Sits between the AXI slave side of the PCIe block and the TLP transmit path; returns the AXI B response once the TLP has fully left.

---
 rtl/pcie_mwr_tlp_packer.sv | 243 ++++++++++++++++++++++++
 tb/tb_pcie_mwr_tlp_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_mwr_tlp_packer.sv
// Packs one AXI write burst (AW + W) into one PCIe Memory-Write TLP, header on the first beat.
// Optional statistics counters are built when PCIE_TLP_STATS_EN is defined.
//
// state  | meaning
// IDLE   | awready high, waiting for the next AW
// DATA   | streaming FIFO beats out as TLP payload
// DRAIN  | illegal burst: discarding its W beats, no TLP
// RESP   | presenting the B response
module pcie_mwr_tlp_packer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LEN    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic [2:0]          cfg_tc,
    input  logic [15:0]         cfg_req_id,
    input  logic [15:0]         cfg_cpl_id,
    output logic                tlp_valid,
    input  logic                tlp_ready,
    output logic                tlp_sop,
    output logic                tlp_eop,
    output logic [DATA_W-1:0]   tlp_data,
    output logic [DATA_W/8-1:0] tlp_be,
    output logic [2:0]          hdr_fmt,
    output logic [4:0]          hdr_type,
    output logic [2:0]          hdr_tc,
    output logic [9:0]          hdr_length,
    output logic [15:0]         hdr_req_id,
    output logic [15:0]         hdr_cpl_id,
    output logic [ADDR_W-1:0]   hdr_addr
`ifdef PCIE_TLP_STATS_EN
    ,
    output logic [31:0]         stat_tlp_cnt,
    output logic [15:0]         stat_err_cnt,
    output logic [31:0]         stat_beat_cnt
`endif
);

    localparam int BYTES    = DATA_W / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN, S_RESP} state_t;

    state_t state, state_n;

    // ---------------- W FIFO ----------------
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [BYTES-1:0]  fifo_strb [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty, push, pop;

    assign empty  = (count == '0);
    assign wready = (count != DEPTH_CNT);
    assign push   = wvalid && wready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= wdata;
            fifo_strb[wr_ptr] <= wstrb;
            fifo_last[wr_ptr] <= wlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- AW legality and header precompute ----------------
    logic [8:0]  aw_beats;
    logic [15:0] aw_bytes;
    logic [16:0] aw_end;
    logic [9:0]  aw_len_dw;
    logic        addr_hi_nz;
    logic        size_err, len_err, cross_err, align_err, aw_err;

    assign aw_beats  = {1'b0, awlen} + 9'd1;
    assign aw_bytes  = 16'(aw_beats) * 16'(BYTES);
    assign aw_end    = {5'd0, awaddr[11:0]} + {1'b0, aw_bytes};
    // 1024 DW wraps to 0 in the 10-bit length field, as PCIe encodes it
    assign aw_len_dw = 10'(aw_beats) * 10'(DATA_W / 32);

    assign size_err  = (awsize != 3'(SIZE_LOG));
    assign len_err   = (32'(aw_beats) > MAX_LEN);
    assign cross_err = (aw_end > 17'd4096);
    assign align_err = |awaddr[SIZE_LOG-1:0];
    assign aw_err    = size_err || len_err || cross_err || align_err;

    generate
        if (ADDR_W > 32) begin : g_addr64
            assign addr_hi_nz = |awaddr[ADDR_W-1:32];
        end else begin : g_addr32
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

    // ---------------- burst context ----------------
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic [2:0]        tc_q, fmt_q;
    logic [15:0]       req_q, cpl_q;
    logic [9:0]        len_dw_q;
    logic              err_q;
    logic              aw_hs, last_beat, wlast_bad;

    assign aw_hs     = awvalid && awready;
    assign last_beat = (beat_cnt == len_q);
    assign wlast_bad = (fifo_last[rd_ptr] != last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            tc_q     <= '0;
            fmt_q    <= '0;
            req_q    <= '0;
            cpl_q    <= '0;
            len_dw_q <= '0;
            err_q    <= 1'b0;
        end else if (aw_hs) begin
            id_q     <= awid;
            addr_q   <= awaddr;
            len_q    <= awlen;
            beat_cnt <= '0;
            tc_q     <= cfg_tc;
            fmt_q    <= addr_hi_nz ? 3'b011 : 3'b010;
            req_q    <= cfg_req_id;
            cpl_q    <= cfg_cpl_id;
            len_dw_q <= aw_len_dw;
            err_q    <= aw_err;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast_bad) err_q <= 1'b1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        awready   = 1'b0;
        tlp_valid = 1'b0;
        pop       = 1'b0;
        bvalid    = 1'b0;
        case (state)
            S_IDLE: begin
                awready = 1'b1;
                if (awvalid) state_n = aw_err ? S_DRAIN : S_DATA;
            end
            S_DATA: begin
                tlp_valid = !empty;
                if (!empty && tlp_ready) begin
                    pop = 1'b1;
                    if (last_beat) state_n = S_RESP;
                end
            end
            S_DRAIN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (last_beat) state_n = S_RESP;
                end
            end
            S_RESP: begin
                bvalid = 1'b1;
                if (bready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    assign tlp_sop    = tlp_valid && (beat_cnt == 8'd0);
    assign tlp_eop    = tlp_valid && last_beat;
    assign tlp_data   = tlp_valid ? fifo_data[rd_ptr] : '0;
    assign tlp_be     = tlp_valid ? fifo_strb[rd_ptr] : '0;
    assign bid        = id_q;
    assign bresp      = (bvalid && err_q) ? 2'b10 : 2'b00;
    assign hdr_fmt    = fmt_q;
    assign hdr_type   = 5'b00000;
    assign hdr_tc     = tc_q;
    assign hdr_length = len_dw_q;
    assign hdr_req_id = req_q;
    assign hdr_cpl_id = cpl_q;
    assign hdr_addr   = addr_q;

`ifdef PCIE_TLP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tlp_cnt  <= '0;
            stat_err_cnt  <= '0;
            stat_beat_cnt <= '0;
        end else begin
            if (tlp_valid && tlp_ready) begin
                stat_beat_cnt <= stat_beat_cnt + 32'd1;
                if (last_beat) stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
            end
            if (bvalid && bready && err_q) stat_err_cnt <= stat_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_mwr_tlp_packer.sv
// Directed bench for pcie_mwr_tlp_packer: expected TLP beats and B responses are queued
// by the stimulus and checked by an independent monitor.
module tb_pcie_mwr_tlp_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         awvalid, awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         wvalid, wready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         bvalid, bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic [2:0]   cfg_tc;
    logic [15:0]  cfg_req_id, cfg_cpl_id;
    logic         tlp_valid, tlp_ready, tlp_sop, tlp_eop;
    logic [127:0] tlp_data;
    logic [15:0]  tlp_be;
    logic [2:0]   hdr_fmt;
    logic [4:0]   hdr_type;
    logic [2:0]   hdr_tc;
    logic [9:0]   hdr_length;
    logic [15:0]  hdr_req_id, hdr_cpl_id;
    logic [31:0]  hdr_addr;
`ifdef PCIE_TLP_STATS_EN
    logic [31:0]  stat_tlp_cnt, stat_beat_cnt;
    logic [15:0]  stat_err_cnt;
`endif

    always #5 clk = ~clk;

    pcie_mwr_tlp_packer dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .cfg_tc(cfg_tc), .cfg_req_id(cfg_req_id), .cfg_cpl_id(cfg_cpl_id),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
        .tlp_data(tlp_data), .tlp_be(tlp_be),
        .hdr_fmt(hdr_fmt), .hdr_type(hdr_type), .hdr_tc(hdr_tc), .hdr_length(hdr_length),
        .hdr_req_id(hdr_req_id), .hdr_cpl_id(hdr_cpl_id), .hdr_addr(hdr_addr)
`ifdef PCIE_TLP_STATS_EN
        , .stat_tlp_cnt(stat_tlp_cnt), .stat_err_cnt(stat_err_cnt), .stat_beat_cnt(stat_beat_cnt)
`endif
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  be;
        logic         sop;
        logic         eop;
        logic [9:0]   len;
        logic [31:0]  addr;
        logic [2:0]   tc;
        logic [15:0]  req;
        logic [15:0]  cpl;
    } tlp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    tlp_t exp_t[$];
    b_t   exp_b[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void exp_beat(input logic [127:0] d, input logic [15:0] be,
                                     input logic sop, input logic eop, input logic [9:0] len,
                                     input logic [31:0] addr, input logic [2:0] tc,
                                     input logic [15:0] req, input logic [15:0] cpl);
        tlp_t e;
        e.data = d; e.be = be; e.sop = sop; e.eop = eop; e.len = len;
        e.addr = addr; e.tc = tc; e.req = req; e.cpl = cpl;
        exp_t.push_back(e);
    endfunction

    function automatic void exp_resp(input logic [3:0] id, input logic [1:0] resp);
        b_t e;
        e.id = id; e.resp = resp;
        exp_b.push_back(e);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    logic [231:0] snap, cur;
    logic         stall_prev = 1'b0;

    assign cur = {tlp_valid, tlp_sop, tlp_eop, tlp_data, tlp_be, hdr_fmt, hdr_type, hdr_tc,
                  hdr_length, hdr_req_id, hdr_cpl_id, hdr_addr};

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (cur !== snap) begin
                    errors++;
                    $display("FAIL stall_hold: got %h want %h", cur, snap);
                end
            end
            if (tlp_valid && tlp_ready) begin
                checks++;
                if (exp_t.size() == 0) begin
                    errors++;
                    $display("FAIL tlp_unexpected: got beat data=%h sop=%b, want no beat", tlp_data, tlp_sop);
                end else begin
                    tlp_t e;
                    e = exp_t.pop_front();
                    if (tlp_data !== e.data || tlp_be !== e.be || tlp_sop !== e.sop ||
                        tlp_eop !== e.eop || hdr_length !== e.len || hdr_addr !== e.addr ||
                        hdr_tc !== e.tc || hdr_req_id !== e.req || hdr_cpl_id !== e.cpl ||
                        hdr_fmt !== 3'b010 || hdr_type !== 5'b00000) begin
                        errors++;
                        $display("FAIL tlp_beat: got data=%h be=%h sop=%b eop=%b len=%0d addr=%h tc=%0d req=%h cpl=%h fmt=%b type=%b want data=%h be=%h sop=%b eop=%b len=%0d addr=%h tc=%0d req=%h cpl=%h fmt=010 type=00000",
                                 tlp_data, tlp_be, tlp_sop, tlp_eop, hdr_length, hdr_addr, hdr_tc,
                                 hdr_req_id, hdr_cpl_id, hdr_fmt, hdr_type,
                                 e.data, e.be, e.sop, e.eop, e.len, e.addr, e.tc, e.req, e.cpl);
                    end
                end
            end
            if (bvalid && bready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: got id=%0d resp=%b want none", bid, bresp);
                end else begin
                    b_t e;
                    e = exp_b.pop_front();
                    if (bid !== e.id || bresp !== e.resp || exp_t.size() != 0) begin
                        errors++;
                        $display("FAIL b_resp: got id=%0d resp=%b pending_beats=%0d want id=%0d resp=%b pending_beats=0",
                                 bid, bresp, exp_t.size(), e.id, e.resp);
                    end
                end
            end
            stall_prev = tlp_valid && !tlp_ready;
            snap       = cur;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_w(input logic [127:0] d, input logic [15:0] s, input logic l);
        int n;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL w_timeout: got wready=0 want 1 within 100 cycles");
        end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL aw_timeout: got awready=0 want 1 within 100 cycles");
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_t.size() != 0 || exp_b.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL done_timeout: got beats=%0d resps=%0d outstanding want 0", exp_t.size(), exp_b.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] d;
        rst = 1'b1; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1; tlp_ready = 1'b1;
        cfg_tc = 3'd0; cfg_req_id = 16'h0123; cfg_cpl_id = 16'h4567;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wready", 128'(wready), 128'd1);
        check("rst_outs", 128'({tlp_valid, bvalid, tlp_sop, tlp_eop, hdr_length, hdr_addr, bresp}), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single beat
        exp_beat({4{32'h01234567}}, 16'hFFFF, 1, 1, 10'd4, 32'h0, 3'd0, 16'h0123, 16'h4567);
        exp_resp(4'd0, 2'b00);
        push_w({4{32'h01234567}}, 16'hFFFF, 1'b1);
        send_aw(4'd0, 32'h0, 8'd0, 3'd4);
        wait_done();

        // 4 beats with a 2-cycle stall; cfg changed after AW must not leak
        cfg_tc = 3'd5; cfg_req_id = 16'hABCD; cfg_cpl_id = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            d = {4{32'hA0000000 + 32'(i)}};
            exp_beat(d, (i == 2) ? 16'h0F0F : 16'hFFFF, i == 0, i == 3, 10'd16, 32'd32, 3'd5, 16'hABCD, 16'h1111);
            push_w(d, (i == 2) ? 16'h0F0F : 16'hFFFF, i == 3);
        end
        exp_resp(4'd3, 2'b00);
        send_aw(4'd3, 32'd32, 8'd3, 3'd4);
        cfg_tc = 3'd7; cfg_req_id = 16'h0; cfg_cpl_id = 16'h0;
        @(posedge clk); #1;
        tlp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tlp_ready = 1'b1;
        wait_done();

        // awsize mismatch
        cfg_tc = 3'd1; cfg_req_id = 16'h2222; cfg_cpl_id = 16'h3333;
        exp_resp(4'd5, 2'b10);
        push_w(128'hDEAD, 16'hFFFF, 1'b1);
        send_aw(4'd5, 32'h0, 8'd0, 3'd3);
        wait_done();

        // 4 KB crossing, then a legal write
        exp_resp(4'd6, 2'b10);
        for (int i = 0; i < 8; i++) push_w(128'(i), 16'hFFFF, i == 7);
        send_aw(4'd6, 32'h0000_0FC0, 8'd7, 3'd4);
        wait_done();
        exp_beat({4{32'hCAFEF00D}}, 16'h00FF, 1, 1, 10'd4, 32'h1000, 3'd1, 16'h2222, 16'h3333);
        exp_resp(4'd7, 2'b00);
        push_w({4{32'hCAFEF00D}}, 16'h00FF, 1'b1);
        send_aw(4'd7, 32'h0000_1000, 8'd0, 3'd4);
        wait_done();

        // W ahead of AW, early wlast, latency
        exp_beat(128'h1111, 16'hFFFF, 1, 0, 10'd8, 32'h200, 3'd1, 16'h2222, 16'h3333);
        exp_beat(128'h2222, 16'hFFFF, 0, 1, 10'd8, 32'h200, 3'd1, 16'h2222, 16'h3333);
        exp_resp(4'd9, 2'b10);
        push_w(128'h1111, 16'hFFFF, 1'b1);
        push_w(128'h2222, 16'hFFFF, 1'b0);
        send_aw(4'd9, 32'h200, 8'd1, 3'd4);
        @(negedge clk);
        check("lat_sop", 128'({tlp_valid, tlp_sop}), 128'b11);
        @(negedge clk);
        check("b2b_eop", 128'({tlp_valid, tlp_eop}), 128'b11);
        wait_done();

        // reset mid-burst, then normal write
        tlp_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_w(128'(i + 16), 16'hFFFF, i == 7);
        send_aw(4'd4, 32'h0, 8'd7, 3'd4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 128'({wready, awready}), 128'b11);
        check("midrst_outs", 128'({tlp_valid, bvalid, tlp_sop, tlp_eop, tlp_data[15:0], hdr_length, hdr_addr}), 128'd0);
        tlp_ready = 1'b1;
        exp_beat({4{32'h55AA55AA}}, 16'hFFFF, 1, 1, 10'd4, 32'h40, 3'd1, 16'h2222, 16'h3333);
        exp_resp(4'd2, 2'b00);
        push_w({4{32'h55AA55AA}}, 16'hFFFF, 1'b1);
        send_aw(4'd2, 32'h40, 8'd0, 3'd4);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
